// File: rtl/operand_stack_pkg.sv
// Shared types for the ALU operand stack: the per-cycle stack command and default depth.
package operand_stack_pkg;

   typedef enum logic [2:0] {
      S_NOP   = 3'd0,
      S_PUSH  = 3'd1,
      S_POP   = 3'd2,
      S_POP2  = 3'd3,
      S_WB1   = 3'd4,
      S_WB2   = 3'd5,
      S_SWAP  = 3'd6,
      S_BINOP = 3'd7
   } stack_op_t;

   localparam int STACK_DEPTH = 8;

endpackage

// File: rtl/operand_stack_if.sv
// Decode/ALU side bundle of the operand stack: command and writeback in, top operands and status out.
interface operand_stack_if
   import operand_stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = STACK_DEPTH
);
   stack_op_t              op;
   logic [WIDTH-1:0]       din;
   logic [WIDTH-1:0]       wb0;
   logic [WIDTH-1:0]       wb1;
   logic [WIDTH-1:0]       top0;
   logic [WIDTH-1:0]       top1;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   full;
   logic                   err;

   modport master (output op, din, wb0, wb1,
                   input  top0, top1, count, empty, full, err);
   modport slave  (input  op, din, wb0, wb1,
                   output top0, top1, count, empty, full, err);
endinterface

// File: rtl/stack_regfile.sv
// Unreset DEPTH x WIDTH storage with two write ports and two asynchronous read ports.
module stack_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [AW-1:0]    wa0,
   input  logic [WIDTH-1:0] wd0,
   input  logic             we0,
   input  logic [AW-1:0]    wa1,
   input  logic [WIDTH-1:0] wd1,
   input  logic             we1,
   input  logic [AW-1:0]    ra0,
   output logic [WIDTH-1:0] rd0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] rd1
);
   logic [WIDTH-1:0] mem [DEPTH];

   // The caller never aims both write ports at the same address in one cycle.
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];
endmodule

// File: rtl/operand_stack.sv
// Operand stack between decode and the ALU: pointer/count/error state, op legality and decode.
module operand_stack
   import operand_stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   operand_stack_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0]    sp, sp_nxt, idx0, idx1;
   logic [CW-1:0]    count, count_nxt;
   logic             err, err_nxt, legal, full;
   logic             we0, we1;
   logic [AW-1:0]    wa0, wa1;
   logic [WIDTH-1:0] wd0, wd1, rd0, rd1;

   // sp points at the next free slot; both top indices wrap mod DEPTH.
   assign idx0 = sp - AW'(1);
   assign idx1 = sp - AW'(2);
   assign full = (count == CW'(DEPTH));

   stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
      .clk (clk),
      .wa0 (wa0), .wd0 (wd0), .we0 (we0),
      .wa1 (wa1), .wd1 (wd1), .we1 (we1),
      .ra0 (idx0), .rd0 (rd0),
      .ra1 (idx1), .rd1 (rd1)
   );

   always_comb begin
      legal = 1'b0;
      case (bus.op)
         S_NOP:          legal = 1'b1;
         S_PUSH:         legal = !full;
         S_POP, S_WB1:   legal = (count >= CW'(1));
         S_POP2, S_WB2,
         S_SWAP, S_BINOP: legal = (count >= CW'(2));
         default:        legal = 1'b0;
      endcase
   end

   always_comb begin
      we0       = 1'b0;
      we1       = 1'b0;
      wa0       = sp;
      wa1       = idx1;
      wd0       = bus.din;
      wd1       = bus.wb1;
      sp_nxt    = sp;
      count_nxt = count;
      err_nxt   = err;
      // An illegal op touches nothing but the sticky error flag.
      if (!legal) begin
         err_nxt = 1'b1;
      end else begin
         case (bus.op)
            S_PUSH: begin
               we0       = 1'b1;
               wa0       = sp;
               wd0       = bus.din;
               sp_nxt    = sp + AW'(1);
               count_nxt = count + CW'(1);
            end
            S_POP: begin
               sp_nxt    = sp - AW'(1);
               count_nxt = count - CW'(1);
            end
            S_POP2: begin
               sp_nxt    = sp - AW'(2);
               count_nxt = count - CW'(2);
            end
            S_WB1: begin
               we0 = 1'b1;
               wa0 = idx0;
               wd0 = bus.wb0;
            end
            S_WB2: begin
               we0 = 1'b1;
               wa0 = idx0;
               wd0 = bus.wb0;
               we1 = 1'b1;
               wa1 = idx1;
               wd1 = bus.wb1;
            end
            S_SWAP: begin
               we0 = 1'b1;
               wa0 = idx0;
               wd0 = rd1;
               we1 = 1'b1;
               wa1 = idx1;
               wd1 = rd0;
            end
            S_BINOP: begin
               // Result lands in the old second slot, which becomes the new top.
               we0       = 1'b1;
               wa0       = idx1;
               wd0       = bus.din;
               sp_nxt    = sp - AW'(1);
               count_nxt = count - CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp    <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         sp    <= sp_nxt;
         count <= count_nxt;
         err   <= err_nxt;
      end
   end

   // Masking keeps stale storage off the ALU operands when the stack is shallow.
   assign bus.top0  = (count >= CW'(1)) ? rd0 : '0;
   assign bus.top1  = (count >= CW'(2)) ? rd1 : '0;
   assign bus.count = count;
   assign bus.empty = (count == '0);
   assign bus.full  = full;
   assign bus.err   = err;
endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: directed scenarios with hand values plus a per-cycle reference model.
module tb_operand_stack;
   import operand_stack_pkg::*;

   typedef struct {
      string      name;
      logic [7:0] t0;
      logic [7:0] t1;
      logic [3:0] cnt;
      logic       emp;
      logic       fl;
      logic       e;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q[$];
   event chk_now;

   logic [7:0] m [8];
   int         msp = 0;
   int         mcnt = 0;
   logic       merr = 1'b0;

   operand_stack_if #(.WIDTH(8), .DEPTH(8)) bus ();
   operand_stack #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk or chk_now) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_checks++;
         if (bus.top0 !== e.t0 || bus.top1 !== e.t1 || bus.count !== e.cnt ||
             bus.empty !== e.emp || bus.full !== e.fl || bus.err !== e.e) begin
            n_fail++;
            $display("FAIL %s: got top0=%h top1=%h count=%0d empty=%b full=%b err=%b, want top0=%h top1=%h count=%0d empty=%b full=%b err=%b",
                     e.name, bus.top0, bus.top1, bus.count, bus.empty, bus.full, bus.err,
                     e.t0, e.t1, e.cnt, e.emp, e.fl, e.e);
         end
      end
   end

   function automatic void model_step(stack_op_t o, logic [7:0] d, logic [7:0] w0, logic [7:0] w1);
      logic [7:0] tmp;
      case (o)
         S_NOP: ;
         S_PUSH:  if (mcnt < 8) begin m[msp] = d; msp = (msp + 1) % 8; mcnt++; end else merr = 1'b1;
         S_POP:   if (mcnt >= 1) begin msp = (msp + 7) % 8; mcnt--; end else merr = 1'b1;
         S_POP2:  if (mcnt >= 2) begin msp = (msp + 6) % 8; mcnt -= 2; end else merr = 1'b1;
         S_WB1:   if (mcnt >= 1) m[(msp + 7) % 8] = w0; else merr = 1'b1;
         S_WB2:   if (mcnt >= 2) begin m[(msp + 7) % 8] = w0; m[(msp + 6) % 8] = w1; end
                  else merr = 1'b1;
         S_SWAP:  if (mcnt >= 2) begin
                     tmp = m[(msp + 7) % 8];
                     m[(msp + 7) % 8] = m[(msp + 6) % 8];
                     m[(msp + 6) % 8] = tmp;
                  end else merr = 1'b1;
         S_BINOP: if (mcnt >= 2) begin m[(msp + 6) % 8] = d; msp = (msp + 7) % 8; mcnt--; end
                  else merr = 1'b1;
         default: merr = 1'b1;
      endcase
   endfunction

   function automatic void push_model(string name);
      exp_t e;
      e.name = name;
      e.t0   = (mcnt >= 1) ? m[(msp + 7) % 8] : 8'h00;
      e.t1   = (mcnt >= 2) ? m[(msp + 6) % 8] : 8'h00;
      e.cnt  = 4'(mcnt);
      e.emp  = (mcnt == 0);
      e.fl   = (mcnt == 8);
      e.e    = merr;
      q.push_back(e);
   endfunction

   function automatic void chk(string name, logic [7:0] t0, logic [7:0] t1, int cnt, logic e);
      exp_t x;
      x.name = name;
      x.t0   = t0;
      x.t1   = t1;
      x.cnt  = 4'(cnt);
      x.emp  = (cnt == 0);
      x.fl   = (cnt == 8);
      x.e    = e;
      q.push_back(x);
   endfunction

   task automatic do_op(stack_op_t o, logic [7:0] d = 8'h00, logic [7:0] w0 = 8'h00,
                        logic [7:0] w1 = 8'h00);
      bus.op  = o;
      bus.din = d;
      bus.wb0 = w0;
      bus.wb1 = w1;
      @(posedge clk);
      model_step(o, d, w0, w1);
      #1;
      push_model("model");
      bus.op = S_NOP;
   endtask

   // Reset is raised and dropped inside one low phase, so no clock edge sees it.
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      msp  = 0;
      mcnt = 0;
      merr = 1'b0;
      #1;
      chk("reset_async", 8'h00, 8'h00, 0, 1'b0);
      ->chk_now;
      #1;
      bus.op = S_NOP;
      reset  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.op  = S_NOP;
      bus.din = 8'h00;
      bus.wb0 = 8'h00;
      bus.wb1 = 8'h00;
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
      do_reset();

      // 1: reset in the middle of a push stream
      do_op(S_PUSH, 8'h01);
      do_op(S_PUSH, 8'h02);
      do_op(S_PUSH, 8'h03);
      chk("push3", 8'h03, 8'h02, 3, 1'b0);
      bus.op  = S_PUSH;
      bus.din = 8'h44;
      do_reset();

      // 2: binop replaces the top two with the result
      do_op(S_PUSH, 8'h05);
      do_op(S_PUSH, 8'h03);
      do_op(S_BINOP, 8'h08);
      chk("binop", 8'h08, 8'h00, 1, 1'b0);

      // 3: fill to full, then overflow
      do_reset();
      for (int i = 1; i <= 8; i++) do_op(S_PUSH, 8'(i));
      chk("full", 8'h08, 8'h07, 8, 1'b0);
      do_op(S_PUSH, 8'h09);
      chk("overflow", 8'h08, 8'h07, 8, 1'b1);

      // 4: underflow conditions
      do_reset();
      do_op(S_POP);
      chk("pop_empty", 8'h00, 8'h00, 0, 1'b1);
      do_reset();
      do_op(S_PUSH, 8'h42);
      chk("one_entry", 8'h42, 8'h00, 1, 1'b0);
      do_op(S_POP2);
      chk("pop2_c1", 8'h42, 8'h00, 1, 1'b1);
      do_op(S_WB2, 8'h00, 8'h77, 8'h66);
      chk("wb2_c1", 8'h42, 8'h00, 1, 1'b1);
      do_op(S_SWAP);
      chk("swap_c1", 8'h42, 8'h00, 1, 1'b1);
      do_op(S_BINOP, 8'h99);
      chk("binop_c1", 8'h42, 8'h00, 1, 1'b1);

      // 5: writeback and swap
      do_reset();
      do_op(S_PUSH, 8'hA0);
      do_op(S_PUSH, 8'h0B);
      do_op(S_WB2, 8'h00, 8'h11, 8'h22);
      chk("wb2", 8'h11, 8'h22, 2, 1'b0);
      do_op(S_SWAP);
      chk("swap", 8'h22, 8'h11, 2, 1'b0);
      do_op(S_WB1, 8'h00, 8'h33, 8'h55);
      chk("wb1", 8'h33, 8'h11, 2, 1'b0);

      // 6: pointer wrap
      do_reset();
      for (int i = 0; i < 6; i++) do_op(S_PUSH, 8'(8'h10 + i));
      for (int i = 0; i < 5; i++) do_op(S_POP);
      chk("wrap_pop", 8'h10, 8'h00, 1, 1'b0);
      for (int i = 0; i < 6; i++) do_op(S_PUSH, 8'(8'h20 + i));
      chk("wrap_push", 8'h25, 8'h24, 7, 1'b0);
      do_op(S_PUSH, 8'h26);
      chk("wrap_full", 8'h26, 8'h25, 8, 1'b0);
      do_op(S_POP2);
      chk("wrap_pop2", 8'h24, 8'h23, 6, 1'b0);

      // Random legal/illegal sequences against the reference model
      for (int n = 0; n < 400; n++) begin
         stack_op_t o;
         if (n % 50 == 0) do_reset();
         if ($urandom_range(0, 3) == 0) o = S_PUSH;
         else o = stack_op_t'($urandom_range(0, 7));
         do_op(o, 8'($urandom), 8'($urandom), 8'($urandom));
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
